// File: rtl/fifo_stream_pkg.sv
// Shared constants and pointer helper for the FIFO-to-stream drain stage.
// The skid buffer is 3 deep, so pointers wrap modulo 3 rather than modulo 4.
package fifo_stream_pkg;

  localparam int BUF_DEPTH      = 3;
  localparam int PTR_W          = 2;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Advance a buffer pointer, wrapping 2 -> 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// 3-entry register buffer holding words captured from the FIFO read port.
// Push writes at tail, pop retires the head entry; occupancy is tracked explicitly.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t                  r_head;
  ptr_t                  r_tail;
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign w_pop = i_pop && (r_occ != 2'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      // Simultaneous push and pop cancel out and leave occupancy unchanged.
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = (r_occ != 2'd0) ? r_mem[r_head] : '0;

  // The upstream credit rule must never let a capture land on a full buffer.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && (r_occ == 2'd3)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle registered read) into a valid/ready stream.
// Credit logic keeps buffered plus in-flight words within the 3-entry skid buffer.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [CNT_WIDTH-1:0]  o_word_count
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [1:0]           w_occ;
  logic [2:0]           w_credit_used;
  logic                 w_rd_en;
  logic                 w_valid;
  logic                 w_pop;

  // Read issue looks only at registered state and fifo_empty, never at m_ready.
  assign w_credit_used = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_rd_en       = i_rst_n && !i_fifo_empty && (w_credit_used < 3'(BUF_DEPTH));

  // Stream handshake: a word transfers on any cycle where m_valid and m_ready
  // are both high; m_valid never drops and m_data never changes until then.
  assign w_pop = w_valid && i_m_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inflight   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_word_count <= r_word_count + CNT_WIDTH'(1);
      end
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_data),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_valid     (w_valid),
    .o_data      (o_m_data)
  );

  assign o_fifo_rd_en = w_rd_en;
  assign o_m_valid    = w_valid;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader driven by a small behavioural FIFO model.
// Words written to the FIFO are queued as expectations and matched at each handshake.
module tb_fifo_stream_reader;

  localparam int DW = 6;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_count;

  // FIFO model controls
  logic          tb_wr_en;
  logic [DW-1:0] tb_wr_data;
  logic          tb_hold;
  logic          tb_force_ne;

  logic [DW-1:0] f_mem [16];
  logic [3:0]    f_wp;
  logic [3:0]    f_rp;
  logic [4:0]    f_cnt;
  logic [DW-1:0] f_dout;
  logic          f_rd;

  // Scoreboard and statistics
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_wc;
  logic [DW-1:0] burst [8];
  logic [DW-1:0] prev_data;
  logic          prev_stall;
  int            n_total;
  int            n_bad;
  int            cyc;
  int            rd_cnt;
  int            val_cnt;
  int            hs_cnt;
  int            rd_first;
  int            val_first;
  int            val_last;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_rd_en (fifo_rd_en),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_word_count (word_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- FIFO model ----------------
  assign fifo_empty = tb_force_ne ? 1'b0 : (tb_hold || (f_cnt == 5'd0));
  assign f_rd       = fifo_rd_en && !fifo_empty;
  assign fifo_data  = f_dout;

  always @(posedge clk) begin
    if (!rst_n) begin
      f_wp   <= '0;
      f_rp   <= '0;
      f_cnt  <= '0;
      f_dout <= '0;
    end else begin
      if (tb_wr_en) begin
        f_mem[f_wp] <= tb_wr_data;
        f_wp        <= f_wp + 4'd1;
      end
      if (f_rd) begin
        f_dout <= f_mem[f_rp];
        f_rp   <= f_rp + 4'd1;
      end
      f_cnt <= f_cnt + {4'd0, tb_wr_en} - {4'd0, f_rd};
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    rd_cnt     = 0;
    val_cnt    = 0;
    hs_cnt     = 0;
    rd_first   = -1;
    val_first  = -1;
    val_last   = -1;
    prev_stall = 1'b0;
  endtask

  // One cycle: monitor at the falling edge, return just after the rising edge.
  task automatic tick();
    logic hs;
    @(negedge clk);
    cyc++;
    hs = m_valid && m_ready && rst_n;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (rd_first < 0) rd_first = cyc;
    end
    if (m_valid) begin
      val_cnt++;
      if (val_first < 0) val_first = cyc;
      val_last = cyc;
    end
    if (fifo_empty) chk("rd_when_empty", {31'd0, fifo_rd_en}, 32'd0);
    if (prev_stall) chk("stall_hold", {25'd0, m_valid, m_data}, {25'd0, 1'b1, prev_data});
    chk("credit", {31'd0, (rd_cnt - hs_cnt) <= 3}, 32'd1);
    chk("wc_track", {16'd0, word_count}, {16'd0, exp_wc});
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", 32'd1, 32'd0);
      end else begin
        chk("sb_data", {26'd0, m_data}, {26'd0, exp_q.pop_front()});
      end
      hs_cnt++;
      exp_wc = exp_wc + 16'd1;
    end
    prev_stall = m_valid && !m_ready && rst_n;
    prev_data  = m_data;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_write(input logic [DW-1:0] d);
    tb_wr_en   = 1'b1;
    tb_wr_data = d;
    exp_q.push_back(d);
    tick();
    tb_wr_en = 1'b0;
  endtask

  // Load the burst while the FIFO reports empty, so it appears preloaded.
  task automatic preload_burst();
    tb_hold = 1'b1;
    for (int i = 0; i < 8; i++) fifo_write(burst[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    n_total     = 0;
    n_bad       = 0;
    cyc         = 0;
    exp_wc      = '0;
    prev_data   = '0;
    rst_n       = 1'b0;
    m_ready     = 1'b1;
    tb_wr_en    = 1'b0;
    tb_wr_data  = '0;
    tb_hold     = 1'b0;
    tb_force_ne = 1'b1;
    burst[0] = 6'b101010; burst[1] = 6'b010101; burst[2] = 6'b000001; burst[3] = 6'b000010;
    burst[4] = 6'b000100; burst[5] = 6'b001000; burst[6] = 6'b010000; burst[7] = 6'b100000;
    clear_stats();

    // Reset hygiene: FIFO claims non-empty, yet nothing may be requested.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data",  {26'd0, m_data}, 32'd0);
      chk("rst_wc",    {16'd0, word_count}, 32'd0);
      @(posedge clk); #1;
    end
    tb_force_ne = 1'b0;
    rst_n       = 1'b1;

    // Single word
    tick();
    clear_stats();
    fifo_write(6'b101010);
    repeat (6) tick();
    chk("single_rd_pulses", rd_cnt, 32'd1);
    chk("single_valid_cycles", val_cnt, 32'd1);
    chk("single_latency", val_first - rd_first, 32'd2);
    chk("single_wc", {16'd0, word_count}, 32'd1);
    chk("single_drained", exp_q.size(), 32'd0);

    // Full burst, consumer always ready
    preload_burst();
    clear_stats();
    tb_hold = 1'b0;
    repeat (14) tick();
    chk("burst_rd_pulses", rd_cnt, 32'd8);
    chk("burst_valid_cycles", val_cnt, 32'd8);
    chk("burst_back_to_back", val_last - val_first, 32'd7);
    chk("burst_wc", {16'd0, word_count}, 32'd9);
    chk("burst_drained", exp_q.size(), 32'd0);

    // Backpressure: only the buffer's worth of reads, head word held
    m_ready = 1'b0;
    preload_burst();
    clear_stats();
    tb_hold = 1'b0;
    repeat (10) tick();
    chk("bp_rd_pulses", rd_cnt, 32'd3);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data", {26'd0, m_data}, {26'd0, 6'b101010});
    m_ready = 1'b1;
    repeat (14) tick();
    chk("bp_total_reads", rd_cnt, 32'd8);
    chk("bp_delivered", hs_cnt, 32'd8);
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_wc", {16'd0, word_count}, 32'd17);

    // Alternating ready with concurrent writes
    clear_stats();
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      fifo_write(6'(i * 5 + 3));
    end
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    chk("alt_delivered", hs_cnt, 32'd12);
    chk("alt_drained", exp_q.size(), 32'd0);
    chk("alt_wc", {16'd0, word_count}, 32'd29);

    // Reset in the middle of a burst
    m_ready = 1'b1;
    preload_burst();
    clear_stats();
    tb_hold = 1'b0;
    k = 0;
    while (hs_cnt < 4 && k < 20) begin
      tick();
      k++;
    end
    chk("mid_reached_4", hs_cnt, 32'd4);
    chk("mid_wc_before", {16'd0, word_count}, 32'd33);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rd_in_rst", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_data",  {26'd0, m_data}, 32'd0);
    chk("mid_rst_wc",    {16'd0, word_count}, 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
    exp_wc = '0;
    rst_n  = 1'b1;
    clear_stats();
    repeat (6) tick();
    chk("post_rst_valid_cycles", val_cnt, 32'd0);
    chk("post_rst_rd_pulses", rd_cnt, 32'd0);
    chk("post_rst_wc", {16'd0, word_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
